// File: rtl/pixel_packer_pkg.sv
// Shared types and constants for the mixed pixel packer.
// Optional drop counter is enabled by defining PIXEL_PACKER_DROP_CNT_EN.
package pixel_packer_pkg;

    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 16;
    localparam int WORD_W       = 64;
    localparam int LANE_W       = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/mixed_pixel_packer_if.sv
// Packed-word burst stream toward the DDR write path.
interface mixed_pixel_packer_if;
    import pixel_packer_pkg::*;

    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input  m_ready);
    modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);

endinterface

// File: rtl/pixel_packer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A write while full is accepted only when a read happens in the same cycle.
module pixel_packer_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_rd   = i_rd_en && !o_empty;
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; the head is read combinationally for fall-through.
    // NOTE: the data array has no reset; the pointers and count define validity, and this keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mixed_pixel_packer.sv
// Packs four RGB444 pixels per 64-bit word, buffers words and emits bursts.
// Define PIXEL_PACKER_DROP_CNT_EN to add the o_drop_cnt dropped-word counter.
module mixed_pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int BURST_LEN    = 16,
    parameter int FIFO_DEPTH   = 64,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     i_pixel_data,
    input  logic                 i_pixel_valid,
    input  logic                 i_frame_start,
    mixed_pixel_packer_if.master m,
    output logic                 o_frame_done,
    output logic                 o_overflow
`ifdef PIXEL_PACKER_DROP_CNT_EN
    ,
    output logic [15:0]          o_drop_cnt
`endif
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int PCNT_W = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BURST_LEN);
    localparam logic [PCNT_W-1:0] PIX_END   = PCNT_W'(FRAME_PIXELS);
    localparam logic [PCNT_W-1:0] PIX_LAST  = PCNT_W'(FRAME_PIXELS - 1);
    localparam logic [LANE_W-1:0] LANE_TOP  = LANE_W'(PIX_PER_WORD - 1);

    // Packer state
    logic [LANE_W-1:0] r_lane;
    logic [PCNT_W-1:0] r_pix_cnt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_next;
    logic              w_accept;
    logic              w_frame_end;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              r_overflow;

    // Output FSM state
    state_t            r_state;
    logic [BEAT_W-1:0] r_beat;
    logic              r_valid;
    logic              r_last;
    logic              r_done;
    logic              r_flush_pend;

    // FIFO view
    logic [WORD_W-1:0] w_fifo_head;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // Pixels past the frame length are ignored until the next frame start.
    assign w_accept    = i_pixel_valid && !i_frame_start && (r_pix_cnt != PIX_END);
    assign w_frame_end = w_accept && (r_pix_cnt == PIX_LAST);
    assign w_push      = w_accept && ((r_lane == LANE_TOP) || w_frame_end);
    assign w_pop       = r_valid && m.m_ready;
    assign w_drop      = w_push && w_fifo_full && !w_pop;

    // Current word with the incoming pixel inserted at the active lane.
    // NOTE: the default copy first keeps this purely combinational (no latch on untouched lanes).
    always_comb begin
        w_word_next = r_word;
        w_word_next[PIX_W*int'(r_lane) +: PIX_W] = i_pixel_data;
    end

    // Lane/pixel counters and partial word; a pushed word restarts from zero lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane    <= '0;
            r_pix_cnt <= '0;
            r_word    <= '0;
        end else if (i_frame_start) begin
            r_lane    <= '0;
            r_pix_cnt <= '0;
            r_word    <= '0;
        end else if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + PCNT_W'(1);
            if (w_push) begin
                r_lane <= '0;
                r_word <= '0;
            end else begin
                r_lane <= r_lane + LANE_W'(1);
                r_word <= w_word_next;
            end
        end
    end

    // Sticky overflow flag, cleared at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_overflow <= 1'b0;
        else if (i_frame_start) r_overflow <= 1'b0;
        else if (w_drop)        r_overflow <= 1'b1;
    end

    pixel_packer_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_word_next),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_head),
        .o_count   (w_fifo_count),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Burst FSM: full bursts take priority over the end-of-frame flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fifo_count >= BURST_CNT) begin
                        r_beat  <= BEAT_FULL;
                        r_last  <= (BEAT_FULL == BEAT_W'(1));
                        r_valid <= 1'b1;
                        r_state <= BURST;
                    end else if (r_flush_pend && !w_fifo_empty) begin
                        r_beat       <= w_fifo_count[BEAT_W-1:0];
                        r_last       <= (w_fifo_count == CNT_W'(1));
                        r_valid      <= 1'b1;
                        r_flush_pend <= 1'b0;
                        r_state      <= FLUSH;
                    end else if (r_flush_pend) begin
                        r_done       <= 1'b1;
                        r_flush_pend <= 1'b0;
                    end
                end
                BURST, FLUSH: begin
                    if (w_pop) begin
                        r_beat <= r_beat - BEAT_W'(1);
                        r_last <= (r_beat == BEAT_W'(2));
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= (r_state == FLUSH);
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_frame_end) r_flush_pend <= 1'b1;
        end
    end

    assign m.m_data     = r_valid ? w_fifo_head : '0;
    assign m.m_valid    = r_valid;
    assign m.m_last     = r_last;
    assign o_frame_done = r_done;
    assign o_overflow   = r_overflow;

`ifdef PIXEL_PACKER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of dropped words, cleared at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_drop_cnt <= '0;
        else if (i_frame_start)                   r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule
